// File: rtl/log_pool_pkg.sv
// Shared types and constants for the multi-log pool: slot state layout and
// the colour value that means "nothing drawn here".
package log_pool_pkg;

  localparam int X_W       = 12;
  localparam int Y_W       = 11;
  localparam int SPD_MAX_W = 8;
  localparam int RGB_W     = 8;

  localparam logic [RGB_W-1:0] TRANSPARENT = 8'hFF;

  // x is held as a 12-bit two's-complement value; callers use $signed on it
  typedef struct packed {
    logic                 active;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [SPD_MAX_W-1:0] speed;
    logic                 dir;
    logic [RGB_W-1:0]     rgb;
  } slot_t;

endpackage

// File: rtl/log_slot.sv
// One log slot: holds position/colour, moves on a tick, retires when it
// leaves the screen and reports whether the current pixel lies inside it.
module log_slot
  import log_pool_pkg::*;
#(
  parameter int OBJ_W    = 64,
  parameter int OBJ_H    = 32,
  parameter int SCREEN_W = 640
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              load,
  input  logic              clear,
  input  logic              tick,
  input  slot_t             load_data,
  input  logic [Y_W-1:0]    pix_x,
  input  logic [Y_W-1:0]    pix_y,
  output logic              active,
  output logic              active_nxt,
  output logic              hit,
  output logic [RGB_W-1:0]  rgb
);

  localparam logic signed [12:0] OBJ_W_S  = 13'(OBJ_W);
  localparam logic signed [12:0] SCREEN_S = 13'(SCREEN_W);
  localparam logic        [12:0] OBJ_H_U  = 13'(OBJ_H);

  slot_t              st;
  logic signed [12:0] x_ext;
  logic signed [12:0] step;
  logic signed [12:0] new_x;
  logic signed [12:0] pix_x_s;
  logic               retire;

  // Movement, retire decision and next-cycle occupancy
  always_comb begin
    x_ext   = $signed({st.x[X_W-1], st.x});
    step    = $signed({5'b0, st.speed});
    new_x   = st.dir ? (x_ext + step) : (x_ext - step);
    retire  = st.dir ? (new_x >= SCREEN_S) : ((new_x + OBJ_W_S) <= 13'sd0);
    active_nxt = st.active;
    if (clear)
      active_nxt = 1'b0;
    else if (load)
      active_nxt = load_data.active;
    else if (st.active && tick && retire)
      active_nxt = 1'b0;
  end

  // Pixel containment test; X compares signed so partly off-screen logs still draw
  always_comb begin
    pix_x_s = $signed({2'b00, pix_x});
    hit = st.active
       && (x_ext <= pix_x_s) && (pix_x_s < (x_ext + OBJ_W_S))
       && ({2'b00, pix_y} >= {2'b00, st.y})
       && ({2'b00, pix_y} < ({2'b00, st.y} + OBJ_H_U));
  end

  // Slot registers; only occupancy is reset, payload is don't-care while free
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      st.active <= 1'b0;
    end else begin
      st.active <= active_nxt;
      if (load) begin
        st.x     <= load_data.x;
        st.y     <= load_data.y;
        st.speed <= load_data.speed;
        st.dir   <= load_data.dir;
        st.rgb   <= load_data.rgb;
      end else if (st.active && tick) begin
        st.x <= new_x[X_W-1:0];
      end
    end
  end

  assign active = st.active;
  assign rgb    = st.rgb;

endmodule

// File: rtl/multi_log_pool.sv
// Pool of independent moving logs: allocates spawns to the lowest free slot,
// resolves pixel hits by lowest index and registers the drawing outputs.
module multi_log_pool
  import log_pool_pkg::*;
#(
  parameter int NUM_SLOTS = 16,
  parameter int OBJ_W     = 64,
  parameter int OBJ_H     = 32,
  parameter int SCREEN_W  = 640,
  parameter int SPEED_W   = 4
) (
  input  logic                         CLK,
  input  logic                         RESETn,
  input  logic                         spawn_valid,
  output logic                         spawn_ready,
  input  logic [10:0]                  spawn_x,
  input  logic [10:0]                  spawn_y,
  input  logic [SPEED_W-1:0]           spawn_speed,
  input  logic                         spawn_dir,
  input  logic [7:0]                   spawn_rgb,
  input  logic                         timer_done,
  input  logic                         freeze,
  input  logic                         clear_all,
  input  logic [10:0]                  oCoord_X,
  input  logic [10:0]                  oCoord_Y,
  output logic                         drawing_request,
  output logic [7:0]                   mVGA_RGB,
  output logic [$clog2(NUM_SLOTS)-1:0] hit_slot,
  output logic [$clog2(NUM_SLOTS):0]   active_count
);

  localparam int IDX_W = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] act;
  logic [NUM_SLOTS-1:0] act_nxt;
  logic [NUM_SLOTS-1:0] hit_vec;
  logic [NUM_SLOTS-1:0] load_vec;
  logic [7:0]           slot_rgb [NUM_SLOTS];
  slot_t                load_d;
  logic                 any_free;
  logic                 tick;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic [7:0]           hit_rgb;
  logic [IDX_W:0]       cnt_nxt;

  assign tick = timer_done && !freeze;

  // Spawn payload as presented to every slot; only the selected one loads it
  always_comb begin
    load_d.active = 1'b1;
    load_d.x      = {spawn_x[10], spawn_x};
    load_d.y      = spawn_y;
    load_d.speed  = SPD_MAX_W'(spawn_speed);
    load_d.dir    = spawn_dir;
    load_d.rgb    = spawn_rgb;
  end

  // Lowest-index free slot gets the spawn; occupancy is the pre-edge view
  always_comb begin
    any_free = 1'b0;
    load_vec = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!act[i]) begin
        any_free = 1'b1;
        load_vec = '0;
        load_vec[i] = spawn_valid && !clear_all;
      end
    end
    spawn_ready = any_free && !clear_all;
  end

  // Lowest-index hit wins; also count slots that will be active after the edge
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_rgb = TRANSPARENT;
    cnt_nxt = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
        hit_rgb = slot_rgb[i];
      end
      cnt_nxt = cnt_nxt + (IDX_W+1)'(act_nxt[i]);
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    log_slot #(
      .OBJ_W   (OBJ_W),
      .OBJ_H   (OBJ_H),
      .SCREEN_W(SCREEN_W)
    ) u_slot (
      .CLK       (CLK),
      .RESETn    (RESETn),
      .load      (load_vec[g]),
      .clear     (clear_all),
      .tick      (tick),
      .load_data (load_d),
      .pix_x     (oCoord_X),
      .pix_y     (oCoord_Y),
      .active    (act[g]),
      .active_nxt(act_nxt[g]),
      .hit       (hit_vec[g]),
      .rgb       (slot_rgb[g])
    );
  end

  // Registered pixel outputs (one cycle after oCoord) and occupancy count
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      drawing_request <= 1'b0;
      mVGA_RGB        <= TRANSPARENT;
      hit_slot        <= '0;
      active_count    <= '0;
    end else begin
      drawing_request <= hit_any;
      mVGA_RGB        <= hit_rgb;
      hit_slot        <= hit_idx;
      active_count    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_multi_log_pool.sv
// Self-checking bench for multi_log_pool: directed scenarios followed by a
// randomized run, all compared against a slot-list reference model.
module tb_multi_log_pool;

  localparam int N  = 16;
  localparam int OW = 64;
  localparam int OH = 32;
  localparam int SW = 640;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [10:0] spawn_x;
  logic [10:0] spawn_y;
  logic [3:0]  spawn_speed;
  logic        spawn_dir;
  logic [7:0]  spawn_rgb;
  logic        timer_done;
  logic        freeze;
  logic        clear_all;
  logic [10:0] oCoord_X;
  logic [10:0] oCoord_Y;
  logic        drawing_request;
  logic [7:0]  mVGA_RGB;
  logic [3:0]  hit_slot;
  logic [4:0]  active_count;

  int tests = 0;
  int fails = 0;

  bit m_act [N];
  int m_x   [N];
  int m_y   [N];
  int m_spd [N];
  int m_dir [N];
  int m_rgb [N];
  int e_draw, e_rgb, e_hit;

  multi_log_pool dut (
    .CLK(CLK), .RESETn(RESETn),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_speed(spawn_speed),
    .spawn_dir(spawn_dir), .spawn_rgb(spawn_rgb),
    .timer_done(timer_done), .freeze(freeze), .clear_all(clear_all),
    .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y),
    .drawing_request(drawing_request), .mVGA_RGB(mVGA_RGB),
    .hit_slot(hit_slot), .active_count(active_count)
  );

  always #5 CLK = ~CLK;

  task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_act[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_act[i] = 1'b0;
  endtask

  // One clock: check spawn_ready before the edge, advance the model, check outputs after
  task automatic cycle();
    bit ready;
    int px, py, slot, nx;
    ready = 1'b0;
    for (int i = 0; i < N; i++) if (!m_act[i]) ready = 1'b1;
    ready = ready && !clear_all;
    px = int'(oCoord_X);
    py = int'(oCoord_Y);
    e_draw = 0; e_rgb = 255; e_hit = 0;
    for (int i = 0; i < N; i++) begin
      if (e_draw == 0 && m_act[i] && m_x[i] <= px && px < m_x[i] + OW
          && m_y[i] <= py && py < m_y[i] + OH) begin
        e_draw = 1; e_rgb = m_rgb[i]; e_hit = i;
      end
    end
    #1;
    expect_eq("spawn_ready", spawn_ready, ready);
    @(posedge CLK);
    if (clear_all) begin
      model_reset();
    end else begin
      slot = -1;
      if (spawn_valid && ready)
        for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
      if (timer_done && !freeze) begin
        for (int i = 0; i < N; i++) begin
          if (m_act[i]) begin
            nx = m_dir[i] ? m_x[i] + m_spd[i] : m_x[i] - m_spd[i];
            m_x[i] = nx;
            if ((m_dir[i] && nx >= SW) || (!m_dir[i] && nx + OW <= 0)) m_act[i] = 1'b0;
          end
        end
      end
      if (slot >= 0) begin
        m_act[slot] = 1'b1;
        m_x[slot]   = int'($signed(spawn_x));
        m_y[slot]   = int'(spawn_y);
        m_spd[slot] = int'(spawn_speed);
        m_dir[slot] = int'(spawn_dir);
        m_rgb[slot] = int'(spawn_rgb);
      end
    end
    #1;
    expect_eq("drawing_request", drawing_request, e_draw);
    expect_eq("mVGA_RGB", mVGA_RGB, e_rgb);
    expect_eq("hit_slot", hit_slot, e_hit);
    expect_eq("active_count", active_count, model_count());
  endtask

  task automatic do_spawn(int x, int y, int s, int d, int c);
    spawn_valid = 1'b1;
    spawn_x = 11'(x); spawn_y = 11'(y); spawn_speed = 4'(s);
    spawn_dir = d[0]; spawn_rgb = 8'(c);
    cycle();
    spawn_valid = 1'b0;
  endtask

  task automatic do_tick(int n);
    repeat (n) begin
      timer_done = 1'b1;
      cycle();
      timer_done = 1'b0;
    end
  endtask

  task automatic do_clear();
    clear_all = 1'b1;
    cycle();
    clear_all = 1'b0;
  endtask

  task automatic set_pix(int x, int y);
    oCoord_X = 11'(x);
    oCoord_Y = 11'(y);
  endtask

  initial begin
    int px, py, k;
    RESETn = 1'b0;
    spawn_valid = 1'b0; spawn_x = '0; spawn_y = '0; spawn_speed = '0;
    spawn_dir = 1'b0; spawn_rgb = '0;
    timer_done = 1'b0; freeze = 1'b0; clear_all = 1'b0;
    oCoord_X = '0; oCoord_Y = '0;
    model_reset();
    #12;
    expect_eq("rst_draw", drawing_request, 0);
    expect_eq("rst_rgb", mVGA_RGB, 8'hFF);
    expect_eq("rst_hit", hit_slot, 0);
    expect_eq("rst_count", active_count, 0);
    expect_eq("rst_ready", spawn_ready, 1);
    @(negedge CLK); RESETn = 1'b1;
    @(posedge CLK); #1;

    // Spawn, three ticks, then probe the moved log
    do_spawn(100, 50, 4, 1, 8'h3C);
    do_tick(3);
    set_pix(112, 50); cycle();
    expect_eq("mv_draw", drawing_request, 1);
    expect_eq("mv_rgb", mVGA_RGB, 8'h3C);
    set_pix(111, 50); cycle();
    expect_eq("mv_left_edge", drawing_request, 0);
    set_pix(175, 81); cycle();
    expect_eq("mv_right_edge", drawing_request, 1);
    set_pix(176, 81); cycle();
    expect_eq("mv_past_edge", drawing_request, 0);
    do_clear();

    // Fill every slot, then an extra spawn must be ignored
    for (int i = 0; i < N; i++) do_spawn(20 * i, 10 * i, 0, 1, i);
    expect_eq("full_count", active_count, 16);
    #1 expect_eq("full_ready", spawn_ready, 0);
    do_spawn(300, 300, 1, 1, 8'h77);
    expect_eq("full_ignored", active_count, 16);
    do_clear();

    // Right-edge retire and immediate reuse
    do_spawn(636, 100, 4, 1, 8'h11);
    do_tick(1);
    expect_eq("rt_retire", active_count, 0);
    do_spawn(10, 10, 1, 1, 8'h22);
    expect_eq("rt_reuse", active_count, 1);
    do_clear();

    // Left-edge retire of a partly off-screen log
    do_spawn(-60, 200, 4, 0, 8'h44);
    set_pix(0, 200); cycle();
    expect_eq("lt_draw", drawing_request, 1);
    expect_eq("lt_rgb", mVGA_RGB, 8'h44);
    do_tick(1);
    expect_eq("lt_retire", active_count, 0);
    do_clear();

    // Overlapping slots 2 and 5: lowest index wins; freeze blocks movement
    for (int i = 0; i < 6; i++) begin
      if (i == 2 || i == 5) do_spawn(200, 100, 3, 1, 8'h20 + i);
      else do_spawn(10, 300, 3, 1, 8'h20 + i);
    end
    set_pix(210, 110); cycle();
    expect_eq("ov_hit", hit_slot, 2);
    expect_eq("ov_rgb", mVGA_RGB, 8'h22);
    freeze = 1'b1; timer_done = 1'b1; cycle();
    freeze = 1'b0; timer_done = 1'b0;
    set_pix(200, 100); cycle();
    expect_eq("frz_draw", drawing_request, 1);
    set_pix(264, 100); cycle();
    expect_eq("frz_edge", drawing_request, 0);

    // Spawn, tick and clear on one edge: clear wins
    spawn_valid = 1'b1; timer_done = 1'b1; clear_all = 1'b1;
    cycle();
    spawn_valid = 1'b0; timer_done = 1'b0; clear_all = 1'b0;
    expect_eq("clr_count", active_count, 0);

    // Asynchronous reset in the middle of activity
    do_spawn(50, 60, 2, 1, 8'h5A);
    do_spawn(400, 60, 2, 0, 8'h5B);
    set_pix(55, 65); cycle();
    expect_eq("pre_rst_draw", drawing_request, 1);
    #2 RESETn = 1'b0;
    #1;
    expect_eq("arst_draw", drawing_request, 0);
    expect_eq("arst_rgb", mVGA_RGB, 8'hFF);
    expect_eq("arst_hit", hit_slot, 0);
    expect_eq("arst_count", active_count, 0);
    model_reset();
    @(negedge CLK); RESETn = 1'b1;
    #1 expect_eq("arst_ready", spawn_ready, 1);
    @(posedge CLK); #1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      spawn_valid = ($urandom_range(0, 99) < 40);
      spawn_x     = 11'(int'($urandom_range(0, 800)) - 100);
      spawn_y     = 11'($urandom_range(0, 479));
      spawn_speed = 4'($urandom_range(0, 15));
      spawn_dir   = 1'($urandom_range(0, 1));
      spawn_rgb   = 8'($urandom_range(0, 255));
      timer_done  = ($urandom_range(0, 99) < 30);
      freeze      = ($urandom_range(0, 99) < 10);
      clear_all   = ($urandom_range(0, 99) < 2);
      k = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1 && m_act[k]) begin
        px = m_x[k] + int'($urandom_range(0, OW));
        py = m_y[k] + int'($urandom_range(0, OH));
        if (px < 0) px = 0;
      end else begin
        px = $urandom_range(0, 700);
        py = $urandom_range(0, 520);
      end
      set_pix(px, py);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
